// File: rtl/microsequencer_if.sv
// Bus between the microsequencer, the IR/microcode ROM, the ALU flags and
// the control decoder. The master side is the microsequencer itself.
interface microsequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int TSTATE_W = 3
);
    logic [OPCODE_W-1:0]          opcode;
    logic [OPCODE_W+TSTATE_W-1:0] ucode_addr;
    logic [15:0]                  ucode_data;
    logic [15:0]                  uinstr;
    logic [TSTATE_W-1:0]          tstate;
    logic                         flag_c;
    logic                         flag_z;
    logic                         flag_gt;
    logic                         flag_lt;
    logic                         pc_load;
    logic                         dev_ready;
    logic                         resume;
    logic                         halted;

    modport master (
        input  opcode, ucode_data, flag_c, flag_z, flag_gt, flag_lt,
               dev_ready, resume,
        output ucode_addr, uinstr, tstate, pc_load, halted
    );

    modport slave (
        output opcode, ucode_data, flag_c, flag_z, flag_gt, flag_lt,
               dev_ready, resume,
        input  ucode_addr, uinstr, tstate, pc_load, halted
    );
endinterface

// File: rtl/microsequencer.sv
// Microcode sequencer: T-state counter, ROM address formation, conditional
// jump strobe, device-transfer stall and HALT handling.
// Optional feature macro: MICROSEQ_STALL_EN (WAIT state on DI/DO until
// dev_ready). Without it DI/DO words advance in one cycle.
module microsequencer #(
    parameter int OPCODE_W = 8,
    parameter int TSTATE_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [TSTATE_W-1:0] tstate_q, tstate_d;

    logic [15:0] d;
    logic        rt, dio, hlt, jump, stall_req, advance;
    logic [15:0] uinstr_c;
    logic        pc_load_c, halted_c;

    // Field decode of the current ROM word
    always_comb begin
        d    = bus.ucode_data;
        rt   = d[15] & d[11];
        dio  = (d[15] & (d[14:12] == 3'd6)) | (d[8:6] == 3'd6);
        hlt  = (d[8:6] == 3'd7);
        jump = (d[5] & bus.flag_c) | (d[4] & bus.flag_z) |
               (d[3] & bus.flag_gt) | (d[2] & bus.flag_lt);
    end

`ifdef MICROSEQ_STALL_EN
    assign stall_req = dio & ~bus.dev_ready;
    logic unused_bits;
    assign unused_bits = ^{d[10:9], d[1:0]};
`else
    // DI/DO are decoded but never stall in this build
    assign stall_req = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{d[10:9], d[1:0], dio, bus.dev_ready};
`endif

    // Next state, T-state advance and per-state outputs
    always_comb begin
        state_d   = state_q;
        tstate_d  = tstate_q;
        uinstr_c  = 16'h0000;
        pc_load_c = 1'b0;
        halted_c  = 1'b0;
        advance   = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d  = S_RUN;
                tstate_d = '0;
            end
            S_RUN: begin
                uinstr_c = d;
                if (stall_req) state_d = S_WAIT;
                else           advance = 1'b1;
            end
`ifdef MICROSEQ_STALL_EN
            S_WAIT: begin
                // Address held, so the device strobes stay asserted
                uinstr_c = d;
                if (bus.dev_ready) advance = 1'b1;
            end
`endif
            S_HALT: begin
                halted_c = 1'b1;
                tstate_d = '0;
                if (bus.resume) state_d = S_RUN;
            end
            default: begin
                state_d  = S_BOOT;
                tstate_d = '0;
            end
        endcase
        // Common advance path; a stalled HLT word lands here after the stall
        if (advance) begin
            pc_load_c = jump;
            if (hlt) begin
                state_d  = S_HALT;
                tstate_d = '0;
            end else begin
                state_d  = S_RUN;
                if (rt || (&tstate_q)) tstate_d = '0;
                else                   tstate_d = tstate_q + TSTATE_W'(1);
            end
        end
    end

    // State and T-state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_BOOT;
            tstate_q <= '0;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
        end
    end

    assign bus.ucode_addr = {bus.opcode, tstate_q};
    assign bus.tstate     = tstate_q;
    assign bus.uinstr     = uinstr_c;
    assign bus.pc_load    = pc_load_c;
    assign bus.halted     = halted_c;
endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios followed by
// randomized ROM contents and inputs, checked against a behavioural model.
module tb_microsequencer;
    localparam int OW = 8;
    localparam int TW = 3;
`ifdef MICROSEQ_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    microsequencer_if #(.OPCODE_W(OW), .TSTATE_W(TW)) bus ();
    microsequencer #(.OPCODE_W(OW), .TSTATE_W(TW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [15:0] rom [0:2047];
    assign bus.ucode_data = rom[bus.ucode_addr];

    int ncmp = 0;
    int nerr = 0;
    int m_mode = M_BOOT;
    int m_t = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input logic [7:0] op, input bit rdy, input bit res, input logic [3:0] fl);
        int addr, dw, nmode, nt;
        bit is_dio, is_hlt, is_rt, jmp, adv;
        int e_ui, e_pc, e_h;
        bus.opcode = op; bus.dev_ready = rdy; bus.resume = res;
        {bus.flag_c, bus.flag_z, bus.flag_gt, bus.flag_lt} = fl;
        #1;
        addr   = op * 8 + m_t;
        dw     = rom[addr];
        is_dio = (((dw / 64) % 8) == 6) || ((dw >= 32768) && (((dw / 4096) % 8) == 6));
        is_hlt = ((dw / 64) % 8) == 7;
        is_rt  = (dw >= 32768) && (((dw / 2048) % 2) == 1);
        jmp    = (((dw / 32) % 2) == 1 && fl[3]) || (((dw / 16) % 2) == 1 && fl[2]) ||
                 (((dw / 8) % 2) == 1 && fl[1]) || (((dw / 4) % 2) == 1 && fl[0]);
        e_ui = 0; e_pc = 0; e_h = 0; nmode = m_mode; nt = m_t; adv = 0;
        case (m_mode)
            M_BOOT: begin nmode = M_RUN; nt = 0; end
            M_RUN: begin
                e_ui = dw;
                if (STALL && is_dio && !rdy) nmode = M_WAIT;
                else adv = 1;
            end
            M_WAIT: begin e_ui = dw; adv = rdy; end
            default: begin e_h = 1; if (res) nmode = M_RUN; end
        endcase
        if (adv) begin
            e_pc = jmp;
            if (is_hlt) begin nmode = M_HALT; nt = 0; end
            else begin nmode = M_RUN; nt = is_rt ? 0 : (m_t + 1) % 8; end
        end
        chk("ucode_addr", 32'(bus.ucode_addr), 32'(addr));
        chk("tstate", 32'(bus.tstate), 32'(m_t));
        chk("uinstr", 32'(bus.uinstr), 32'(e_ui));
        chk("pc_load", 32'(bus.pc_load), 32'(e_pc));
        chk("halted", 32'(bus.halted), 32'(e_h));
        @(posedge clk);
        m_mode = nmode; m_t = nt;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle; called at a falling edge.
    task automatic do_reset(input logic [7:0] op);
        bus.opcode = op;
        #2 reset = 1'b1;
        #1;
        chk("rst_uinstr", 32'(bus.uinstr), 32'h0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_tstate", 32'(bus.tstate), 32'h0);
        chk("rst_addr", 32'(bus.ucode_addr), 32'(op) * 8);
        m_mode = M_BOOT; m_t = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] ops [4];
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        bus.opcode = 8'h12; bus.dev_ready = 1'b1; bus.resume = 1'b0;
        {bus.flag_c, bus.flag_z, bus.flag_gt, bus.flag_lt} = 4'h0;
        @(negedge clk);

        // Plain fallthrough: 0x090..0x097 then wrap
        do_reset(8'h12);
        repeat (11) cycle(8'h12, 1'b1, 1'b0, 4'h0);

        // RT at T2
        rom[{8'h12, 3'd2}] = 16'h8800;
        repeat (8) cycle(8'h12, 1'b1, 1'b0, 4'h0);

        // DO word at T1 held for three not-ready cycles
        rom[{8'h34, 3'd1}] = 16'hE000;
        do_reset(8'h34);
        cycle(8'h34, 1'b1, 1'b0, 4'h0);
        cycle(8'h34, 1'b1, 1'b0, 4'h0);
        repeat (3) cycle(8'h34, 1'b0, 1'b0, 4'h0);
        chk("wait_tstate", 32'(bus.tstate), STALL ? 32'd1 : 32'd4);
        repeat (3) cycle(8'h34, 1'b1, 1'b0, 4'h0);

        // JZ with and without flag_z, and a JZ+DO word that stalls
        rom[{8'h56, 3'd0}] = 16'h0010;
        rom[{8'h56, 3'd2}] = 16'hE010;
        do_reset(8'h56);
        repeat (9) cycle(8'h56, 1'b1, 1'b0, 4'b0100);
        repeat (8) cycle(8'h56, 1'b1, 1'b0, 4'b1011);
        repeat (2) cycle(8'h56, 1'b1, 1'b0, 4'b0100);
        repeat (2) cycle(8'h56, 1'b0, 1'b0, 4'b0100);
        repeat (3) cycle(8'h56, 1'b1, 1'b0, 4'b0100);

        // HLT at T3, resume, then reset while halted
        rom[{8'h78, 3'd3}] = 16'h01C0;
        do_reset(8'h78);
        repeat (8) cycle(8'h78, 1'b1, 1'b0, 4'h0);
        chk("halt_flag", 32'(bus.halted), 32'h1);
        cycle(8'h78, 1'b1, 1'b1, 4'h0);
        repeat (6) cycle(8'h78, 1'b1, 1'b0, 4'h0);
        do_reset(8'h78);
        repeat (4) cycle(8'h78, 1'b1, 1'b0, 4'h0);

        // Reset during a DO stall
        do_reset(8'h34);
        repeat (4) cycle(8'h34, 1'b0, 1'b0, 4'h0);
        do_reset(8'h34);
        repeat (5) cycle(8'h34, 1'b1, 1'b0, 4'h0);

        // Random ROM and inputs
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) ops[i] = 8'($urandom);
        op = ops[0];
        do_reset(op);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) op = ops[$urandom_range(0, 3)];
            if ($urandom_range(0, 99) == 0) do_reset(op);
            else cycle(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                       4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
